// File: rtl/seg7_seq_checker_pkg.sv
// Shared constants for the seven-segment staircase checker: segment codes,
// FSM state encoding and the run-length wrap limit.
package seg7_seq_checker_pkg;

    localparam logic [3:0] WRAP_LIMIT = 4'd9;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEARN = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    // Run maximum after t: t+1, folding anything past the limit back to 1
    function automatic logic [3:0] next_run_len(input logic [3:0] t);
        return (t >= WRAP_LIMIT) ? 4'd1 : t + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_seq_checker_decode.sv
// Combinational seven-segment decoder: maps a legal code to its digit and
// flags every other pattern as illegal (digit forced to 0).
module seg7_decode
    import seg7_seq_checker_pkg::*;
(
    input  logic [6:0] code_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        case (code_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_seq_checker.sv
// Staircase sequence checker: aligns to the 0..T, 0..T+1, ... digit stream,
// then counts completed runs and flags any deviation while locked.
module seg7_seq_checker
    import seg7_seq_checker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seg_valid,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_ok,
    output logic             locked,
    output logic [3:0]       run_len,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] runs_done,
    output logic [1:0]       state_dbg
);

    logic [3:0] dec_digit;
    logic       dec_legal;

    seg7_decode u_decode (
        .code_i  (seg_in),
        .digit_o (dec_digit),
        .legal_o (dec_legal)
    );

    state_e           state_q, state_d;
    logic [3:0]       last_q, last_d;
    logic [3:0]       t_q, t_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_ok_q, digit_ok_d;
    logic             locked_q, locked_d;
    logic [3:0]       run_len_q, run_len_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] runs_q, runs_d;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        t_d        = t_q;
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        digit_ok_d = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        runs_d     = runs_q;

        if (seg_valid) begin
            if (dec_legal) begin
                digit_d    = dec_digit;
                digit_ok_d = 1'b1;
            end
            case (state_q)
                ST_HUNT: begin
                    if (dec_legal && dec_digit == 4'd0) begin
                        state_d = ST_LEARN;
                        last_d  = 4'd0;
                    end
                end
                ST_LEARN: begin
                    if (!dec_legal) begin
                        state_d = ST_HUNT;
                    end else if (last_q < WRAP_LIMIT && dec_digit == last_q + 4'd1) begin
                        last_d = dec_digit;
                    end else if (dec_digit == 4'd0 && last_q >= 4'd1) begin
                        // The run just seen had maximum last, so the next one is last+1
                        t_d     = next_run_len(last_q);
                        cnt_d   = 4'd0;
                        state_d = ST_TRACK;
                    end else if (dec_digit != 4'd0) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_TRACK: begin
                    if (dec_legal && cnt_q < t_q && dec_digit == cnt_q + 4'd1) begin
                        cnt_d = dec_digit;
                    end else if (dec_legal && dec_digit == 4'd0 && cnt_q == t_q) begin
                        cnt_d  = 4'd0;
                        runs_d = runs_q + CNT_ONE;
                        t_d    = next_run_len(t_q);
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        locked_d  = (state_d == ST_TRACK);
        run_len_d = locked_d ? t_d : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            last_q     <= 4'd0;
            t_q        <= 4'd1;
            cnt_q      <= 4'd0;
            digit_q    <= 4'd0;
            digit_ok_q <= 1'b0;
            locked_q   <= 1'b0;
            run_len_q  <= 4'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            runs_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            t_q        <= t_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            digit_ok_q <= digit_ok_d;
            locked_q   <= locked_d;
            run_len_q  <= run_len_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            runs_q     <= runs_d;
        end
    end

    assign digit     = digit_q;
    assign digit_ok  = digit_ok_q;
    assign locked    = locked_q;
    assign run_len   = run_len_q;
    assign err_pulse = err_q;
    assign err_cnt   = err_cnt_q;
    assign runs_done = runs_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seg7_seq_checker.sv
// Directed bench for seg7_seq_checker: each strobe pushes its hand-derived
// response into a queue that a monitor pops one clock later.
`timescale 1ns/1ps
module tb_seg7_seq_checker;

    localparam logic [1:0] H = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] K = 2'd2;
    localparam logic [6:0] SEG_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seg_valid = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic [3:0] digit;
    logic       digit_ok;
    logic       locked;
    logic [3:0] run_len;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] runs_done;
    logic [1:0] state_dbg;

    seg7_seq_checker #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (seg_valid),
        .seg_in    (seg_in),
        .digit     (digit),
        .digit_ok  (digit_ok),
        .locked    (locked),
        .run_len   (run_len),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .runs_done (runs_done),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] digit;
        logic       ok;
        logic       locked;
        logic [3:0] run_len;
        logic       err;
        logic [7:0] err_cnt;
        logic [7:0] runs;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    logic [6:0] seg_lut [0:9];
    logic [7:0] exp_err_cnt = 8'd0;
    logic [7:0] exp_runs = 8'd0;
    int checks = 0;
    int failures = 0;
    logic pending = 1'b0;
    logic started = 1'b0;

    // Driver tasks
    task automatic push_exp(input int dig, input bit ok, input bit lck, input int len,
                            input bit err, input logic [1:0] st);
        exp_t e;
        e.digit   = 4'(dig);
        e.ok      = ok;
        e.locked  = lck;
        e.run_len = 4'(len);
        e.err     = err;
        e.err_cnt = exp_err_cnt;
        e.runs    = exp_runs;
        e.state   = st;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [6:0] code, input int dig, input bit ok, input bit lck,
                          input int len, input bit err, input bit run_inc, input logic [1:0] st);
        @(negedge clk);
        if (err && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
        if (run_inc) exp_runs = exp_runs + 8'd1;
        push_exp(dig, ok, lck, len, err, st);
        seg_valid = 1'b1;
        seg_in    = code;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic reset_cycle(input bit with_strobe, input logic [6:0] code);
        @(negedge clk);
        exp_err_cnt = 8'd0;
        exp_runs    = 8'd0;
        push_exp(0, 1'b0, 1'b0, 0, 1'b0, H);
        rst       = 1'b1;
        seg_valid = with_strobe;
        seg_in    = code;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        seg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One complete run 1..t followed by its closing 0, while locked at T=t
    task automatic run_stair(input int t);
        int nt;
        nt = (t == 9) ? 1 : t + 1;
        for (int k = 1; k <= t; k++) strobe(seg_lut[k], k, 1, 1, t, 0, 0, K);
        strobe(seg_lut[0], 0, 1, 1, nt, 0, 1, K);
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        pending <= seg_valid || rst;
        if (rst) started <= 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: DUT output with no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                a = '{digit, digit_ok, locked, run_len, err_pulse, err_cnt, runs_done, state_dbg};
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs at %0t: got dig=%0d ok=%0d lck=%0d len=%0d err=%0d ecnt=%0d runs=%0d st=%0d, exp dig=%0d ok=%0d lck=%0d len=%0d err=%0d ecnt=%0d runs=%0d st=%0d",
                             $time, a.digit, a.ok, a.locked, a.run_len, a.err, a.err_cnt, a.runs, a.state,
                             e.digit, e.ok, e.locked, e.run_len, e.err, e.err_cnt, e.runs, e.state);
                end
            end
        end else if (started) begin
            checks++;
            if (digit_ok !== 1'b0 || err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL idle_pulses at %0t: got ok=%0b err=%0b, exp 0 0", $time, digit_ok, err_pulse);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
        seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
        seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000; seg_lut[8] = 7'b0000000;
        seg_lut[9] = 7'b0010000;

        reset_cycle(1'b0, 7'd0);
        reset_cycle(1'b1, seg_lut[0]);
        idle(2);

        // Alignment: 0,1 learns T=1, the next 0 locks with T=2
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        idle(1);
        strobe(seg_lut[1], 1, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[0], 0, 1, 1, 2, 0, 0, K);
        idle(3);
        strobe(seg_lut[1], 1, 1, 1, 2, 0, 0, K);
        strobe(seg_lut[2], 2, 1, 1, 2, 0, 0, K);
        strobe(seg_lut[0], 0, 1, 1, 3, 0, 1, K);
        strobe(seg_lut[1], 1, 1, 1, 3, 0, 0, K);
        strobe(seg_lut[2], 2, 1, 1, 3, 0, 0, K);
        strobe(seg_lut[3], 3, 1, 1, 3, 0, 0, K);
        strobe(seg_lut[0], 0, 1, 1, 4, 0, 1, K);

        // Remaining runs up to T=9, wrap to T=1, then back to T=2
        for (int t = 4; t <= 9; t++) run_stair(t);
        run_stair(1);

        // Locked at T=3 with cnt=1, then a wrong legal digit
        run_stair(2);
        strobe(seg_lut[1], 1, 1, 1, 3, 0, 0, K);
        strobe(seg_lut[7], 7, 1, 0, 0, 1, 0, H);
        idle(2);

        // Relock, then an illegal code while locked holds the digit
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[1], 1, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[0], 0, 1, 1, 2, 0, 0, K);
        strobe(seg_lut[1], 1, 1, 1, 2, 0, 0, K);
        strobe(SEG_BAD,    1, 0, 0, 0, 1, 0, H);

        // Silent mismatches in HUNT and LEARN
        strobe(SEG_BAD,    1, 0, 0, 0, 0, 0, H);
        strobe(seg_lut[5], 5, 1, 0, 0, 0, 0, H);
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[2], 2, 1, 0, 0, 0, 0, H);
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        strobe(SEG_BAD,    0, 0, 0, 0, 0, 0, H);

        // Reset wins over a strobed error while locked
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[1], 1, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[0], 0, 1, 1, 2, 0, 0, K);
        reset_cycle(1'b1, seg_lut[7]);
        idle(1);

        // 2^8+3 errors: err_cnt saturates at 255
        for (int i = 0; i < 259; i++) begin
            strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
            strobe(seg_lut[1], 1, 1, 0, 0, 0, 0, L);
            strobe(seg_lut[0], 0, 1, 1, 2, 0, 0, K);
            strobe(seg_lut[7], 7, 1, 0, 0, 1, 0, H);
        end

        // Learning a T=9 run folds the next T to 1
        strobe(seg_lut[0], 0, 1, 0, 0, 0, 0, L);
        for (int k = 1; k <= 9; k++) strobe(seg_lut[k], k, 1, 0, 0, 0, 0, L);
        strobe(seg_lut[0], 0, 1, 1, 1, 0, 0, K);
        run_stair(1);
        strobe(seg_lut[1], 1, 1, 1, 2, 0, 0, K);

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
